// File: rtl/axi_read_arbiter_n_if.sv
// Signal bundle between the read requesters, the arbiter and the AXI AR/R port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface axi_read_arbiter_n_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [NUM_CH-1:0]        ch_req_valid_i;
  logic [NUM_CH-1:0]        ch_req_ready_o;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr_i;
  logic [NUM_CH*8-1:0]      ch_req_len_i;
  logic [NUM_CH-1:0]        ch_resp_valid_o;
  logic [NUM_CH-1:0]        ch_resp_ready_i;
  logic [DATA_W-1:0]        ch_resp_data_o;
  logic                     ch_resp_last_o;
  logic                     ch_resp_err_o;
  logic                     stray_id_o;
  logic                     ar_valid_o;
  logic                     ar_ready_i;
  logic [ADDR_W-1:0]        ar_addr_o;
  logic [7:0]               ar_len_o;
  logic [2:0]               ar_size_o;
  logic [1:0]               ar_burst_o;
  logic [ID_W-1:0]          ar_id_o;
  logic                     r_valid_i;
  logic                     r_ready_o;
  logic [DATA_W-1:0]        r_data_i;
  logic [ID_W-1:0]          r_id_i;
  logic [1:0]               r_resp_i;
  logic                     r_last_i;

  modport master (
    input  ch_req_valid_i, ch_req_addr_i, ch_req_len_i, ch_resp_ready_i,
    input  ar_ready_i, r_valid_i, r_data_i, r_id_i, r_resp_i, r_last_i,
    output ch_req_ready_o, ch_resp_valid_o, ch_resp_data_o, ch_resp_last_o,
    output ch_resp_err_o, stray_id_o, ar_valid_o, ar_addr_o, ar_len_o,
    output ar_size_o, ar_burst_o, ar_id_o, r_ready_o
  );

  modport slave (
    output ch_req_valid_i, ch_req_addr_i, ch_req_len_i, ch_resp_ready_i,
    output ar_ready_i, r_valid_i, r_data_i, r_id_i, r_resp_i, r_last_i,
    input  ch_req_ready_o, ch_resp_valid_o, ch_resp_data_o, ch_resp_last_o,
    input  ch_resp_err_o, stray_id_o, ar_valid_o, ar_addr_o, ar_len_o,
    input  ar_size_o, ar_burst_o, ar_id_o, r_ready_o
  );
endinterface

// File: rtl/axi_read_arbiter_n.sv
// Round-robin N-channel read arbiter onto one AXI4 AR/R port with per-channel
// outstanding limits, ID-based response routing and sticky stray-ID flag.
module axi_read_arbiter_n #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  axi_read_arbiter_n_if.master bus
);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic              ar_valid_reg;
  logic [ADDR_W-1:0] ar_addr_reg;
  logic [7:0]        ar_len_reg;
  logic [ID_W-1:0]   ar_id_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic              stray_reg;

  logic [NUM_CH-1:0] eligible;
  logic              slot_free;
  logic              any_eligible;
  logic              grant_valid;
  logic [PTR_W-1:0]  winner;
  logic              id_in_range;
  logic              r_hs;

  assign slot_free   = !ar_valid_reg || bus.ar_ready_i;
  assign grant_valid = slot_free && any_eligible;

  // First eligible channel at or after rr_ptr, wrapping; idx is one bit wider
  // so the wrap can be done with a single conditional subtract.
  always_comb begin
    logic [PTR_W:0] idx;
    any_eligible = 1'b0;
    winner       = '0;
    idx          = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_CH)) begin
        idx = idx - (PTR_W+1)'(NUM_CH);
      end
      if (!any_eligible && eligible[idx[PTR_W-1:0]]) begin
        any_eligible = 1'b1;
        winner       = idx[PTR_W-1:0];
      end
    end
  end

  assign id_in_range = 32'(bus.r_id_i) < NUM_CH;
  assign bus.r_ready_o = id_in_range ? bus.ch_resp_ready_i[bus.r_id_i[PTR_W-1:0]] : 1'b1;
  assign r_hs = bus.r_valid_i && bus.r_ready_o;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] outst_reg;
      logic             inc;
      logic             dec;
      logic             id_match;

      assign id_match = id_in_range && (bus.r_id_i == ID_W'(gi));
      assign eligible[gi] = bus.ch_req_valid_i[gi] && (outst_reg < CNT_W'(MAX_OUTST));
      assign bus.ch_req_ready_o[gi]  = grant_valid && (winner == PTR_W'(gi));
      assign bus.ch_resp_valid_o[gi] = bus.r_valid_i && id_match;
      assign inc = grant_valid && (winner == PTR_W'(gi));
      assign dec = r_hs && bus.r_last_i && id_match;

      // Decrement at zero is dropped so stale bursts after reset cannot wrap.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          outst_reg <= '0;
        end else if (inc && !dec) begin
          outst_reg <= outst_reg + 1'b1;
        end else if (dec && !inc && (outst_reg != '0)) begin
          outst_reg <= outst_reg - 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ar_valid_reg <= 1'b0;
      ar_addr_reg  <= '0;
      ar_len_reg   <= '0;
      ar_id_reg    <= '0;
      rr_ptr_reg   <= '0;
    end else if (slot_free) begin
      if (grant_valid) begin
        ar_valid_reg <= 1'b1;
        ar_addr_reg  <= bus.ch_req_addr_i[int'(winner)*ADDR_W +: ADDR_W];
        ar_len_reg   <= bus.ch_req_len_i[int'(winner)*8 +: 8];
        ar_id_reg    <= ID_W'(winner);
        rr_ptr_reg   <= (winner == PTR_W'(NUM_CH-1)) ? '0 : winner + 1'b1;
      end else begin
        ar_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stray_reg <= 1'b0;
    end else if (bus.r_valid_i && !id_in_range) begin
      stray_reg <= 1'b1;
    end
  end

  assign bus.ar_valid_o     = ar_valid_reg;
  assign bus.ar_addr_o      = ar_addr_reg;
  assign bus.ar_len_o       = ar_len_reg;
  assign bus.ar_id_o        = ar_id_reg;
  assign bus.ar_size_o      = 3'($clog2(DATA_W/8));
  assign bus.ar_burst_o     = 2'b01;
  assign bus.ch_resp_data_o = bus.r_data_i;
  assign bus.ch_resp_last_o = bus.r_last_i;
  assign bus.ch_resp_err_o  = (bus.r_resp_i != 2'b00);
  assign bus.stray_id_o     = stray_reg;
endmodule

// File: tb/tb_axi_read_arbiter_n.sv
// Bench for axi_read_arbiter_n: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, counters and routing.
module tb_axi_read_arbiter_n;
  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 40;
  localparam int DATA_W    = 64;
  localparam int ID_W      = 4;
  localparam int MAX_OUTST = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_read_arbiter_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_read_arbiter_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int                m_outst[NUM_CH];
  int                m_rr;
  bit                m_av;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_len;
  int                m_id;
  bit                m_stray;

  task automatic set_req(int ch, logic [ADDR_W-1:0] a, logic [7:0] l);
    bus.ch_req_addr_i[ch*ADDR_W +: ADDR_W] = a;
    bus.ch_req_len_i[ch*8 +: 8] = l;
  endtask

  task automatic idle();
    bus.ch_req_valid_i  = '0;
    bus.ch_req_addr_i   = '0;
    bus.ch_req_len_i    = '0;
    bus.ch_resp_ready_i = '0;
    bus.ar_ready_i      = 1'b0;
    bus.r_valid_i       = 1'b0;
    bus.r_data_i        = '0;
    bus.r_id_i          = '0;
    bus.r_resp_i        = 2'b00;
    bus.r_last_i        = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_outst[i] = 0;
    m_rr = 0; m_av = 0; m_addr = '0; m_len = '0; m_id = 0; m_stray = 0;
  endtask

  // Winner per the round-robin rule, or -1 when nothing can be granted.
  function automatic int model_winner();
    if (m_av && !bus.ar_ready_i) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (bus.ch_req_valid_i[c] && m_outst[c] < MAX_OUTST) return c;
    end
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ready();
    int w;
    w = model_winner();
    return (w < 0) ? '0 : (NUM_CH'(1) << w);
  endfunction

  function automatic logic exp_r_ready();
    int id;
    id = int'(bus.r_id_i);
    return (id < NUM_CH) ? bus.ch_resp_ready_i[id] : 1'b1;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_resp_valid();
    int id;
    id = int'(bus.r_id_i);
    return (bus.r_valid_i && id < NUM_CH) ? (NUM_CH'(1) << id) : '0;
  endfunction

  // Advance the model by the current inputs, then one clock.
  task automatic step();
    int w;
    int id;
    bit dec;
    w   = model_winner();
    id  = int'(bus.r_id_i);
    dec = bus.r_valid_i && (id < NUM_CH) && bus.r_last_i && (id < NUM_CH ? bus.ch_resp_ready_i[id] : 1'b0);
    if (m_av && bus.ar_ready_i)
      $display("AR accepted id=%0d addr=%h len=%0d", m_id, m_addr, m_len);
    if (w >= 0 && !(dec && w == id)) m_outst[w]++;
    if (dec && w != id && m_outst[id] > 0) m_outst[id]--;
    if (!m_av || bus.ar_ready_i) begin
      if (w >= 0) begin
        m_av   = 1;
        m_addr = bus.ch_req_addr_i[w*ADDR_W +: ADDR_W];
        m_len  = bus.ch_req_len_i[w*8 +: 8];
        m_id   = w;
        m_rr   = (w + 1) % NUM_CH;
      end else begin
        m_av = 0;
      end
    end
    if (bus.r_valid_i && id >= NUM_CH) m_stray = 1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    model_reset();
    #1;
    total++; if (bus.ar_valid_o !== 1'b0) begin bad++; $display("FAIL reset_ar_valid got=%b exp=0", bus.ar_valid_o); end
    total++; if (bus.stray_id_o !== 1'b0) begin bad++; $display("FAIL reset_stray got=%b exp=0", bus.stray_id_o); end
    total++; if (bus.ar_addr_o !== '0) begin bad++; $display("FAIL reset_ar_addr got=%h exp=0", bus.ar_addr_o); end
    total++; if (bus.ar_len_o !== 8'd0) begin bad++; $display("FAIL reset_ar_len got=%0d exp=0", bus.ar_len_o); end
    total++; if (bus.ar_id_o !== '0) begin bad++; $display("FAIL reset_ar_id got=%0d exp=0", bus.ar_id_o); end
    total++; if (bus.ar_size_o !== 3'd3) begin bad++; $display("FAIL ar_size got=%0d exp=3", bus.ar_size_o); end
    total++; if (bus.ar_burst_o !== 2'b01) begin bad++; $display("FAIL ar_burst got=%b exp=01", bus.ar_burst_o); end
    total++; if (bus.ch_req_ready_o !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.ch_req_ready_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d;
    do_reset();
    set_req(1, 40'h80001000, 8'd3);
    bus.ch_req_valid_i = 4'b0010;
    bus.ar_ready_i = 1'b1;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", bus.ch_req_ready_o); end
    step();
    bus.ch_req_valid_i = '0;
    #1;
    total++; if (bus.ar_valid_o !== 1'b1) begin bad++; $display("FAIL single_ar_valid got=%b exp=1", bus.ar_valid_o); end
    total++; if (bus.ar_id_o !== ID_W'(1)) begin bad++; $display("FAIL single_ar_id got=%0d exp=1", bus.ar_id_o); end
    total++; if (bus.ar_len_o !== 8'd3) begin bad++; $display("FAIL single_ar_len got=%0d exp=3", bus.ar_len_o); end
    total++; if (bus.ar_addr_o !== 40'h80001000) begin bad++; $display("FAIL single_ar_addr got=%h exp=80001000", bus.ar_addr_o); end
    step();
    bus.ch_resp_ready_i = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      d = {$urandom(), $urandom()};
      bus.r_valid_i = 1'b1; bus.r_id_i = ID_W'(1); bus.r_last_i = (b == 3); bus.r_data_i = d;
      #1;
      total++; if (bus.ch_resp_valid_o !== 4'b0010) begin bad++; $display("FAIL single_resp_valid beat=%0d got=%b exp=0010", b, bus.ch_resp_valid_o); end
      total++; if (bus.r_ready_o !== 1'b1) begin bad++; $display("FAIL single_r_ready beat=%0d got=%b exp=1", b, bus.r_ready_o); end
      total++; if (bus.ch_resp_data_o !== d) begin bad++; $display("FAIL single_data beat=%0d got=%h exp=%h", b, bus.ch_resp_data_o, d); end
      total++; if (bus.ch_resp_last_o !== (b == 3)) begin bad++; $display("FAIL single_last beat=%0d got=%b", b, bus.ch_resp_last_o); end
      step();
    end
    bus.r_valid_i = 1'b0; bus.r_last_i = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_req(c, ADDR_W'(32'h1000 * (c + 1)), 8'd0);
    bus.ch_req_valid_i = 4'b1111;
    bus.ar_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (bus.ch_req_ready_o !== NUM_CH'(1 << (k % 4))) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.ch_req_ready_o, NUM_CH'(1 << (k % 4))); end
      if (k > 0) begin
        total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_id_o !== ID_W'((k - 1) % 4)) begin bad++; $display("FAIL rr_ar_id k=%0d got=%0d exp=%0d", k, bus.ar_id_o, (k - 1) % 4); end
      end
      step();
    end
    bus.ch_req_valid_i = '0;
    step();
  endtask

  task automatic test_ar_backpressure();
    do_reset();
    set_req(2, 40'hA2000, 8'd7);
    set_req(3, 40'hA3000, 8'd1);
    bus.ch_req_valid_i = 4'b1100;
    bus.ar_ready_i = 1'b0;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0100) begin bad++; $display("FAIL bp_first_ready got=%b exp=0100", bus.ch_req_ready_o); end
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_id_o !== ID_W'(2) || bus.ar_addr_o !== 40'hA2000 || bus.ar_len_o !== 8'd7) begin
        bad++; $display("FAIL bp_hold k=%0d valid=%b id=%0d addr=%h len=%0d exp 1/2/a2000/7", k, bus.ar_valid_o, bus.ar_id_o, bus.ar_addr_o, bus.ar_len_o);
      end
      total++; if (bus.ch_req_ready_o !== 4'b0000) begin bad++; $display("FAIL bp_no_ready k=%0d got=%b exp=0000", k, bus.ch_req_ready_o); end
      step();
    end
    bus.ar_ready_i = 1'b1;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b exp=1000", bus.ch_req_ready_o); end
    step();
    bus.ch_req_valid_i = '0;
    #1;
    total++; if (bus.ar_id_o !== ID_W'(3) || bus.ar_addr_o !== 40'hA3000) begin bad++; $display("FAIL bp_second got id=%0d addr=%h exp 3/a3000", bus.ar_id_o, bus.ar_addr_o); end
    step();
  endtask

  task automatic test_outst_limit();
    do_reset();
    set_req(0, 40'hB000, 8'd0);
    set_req(1, 40'hB100, 8'd0);
    bus.ch_req_valid_i = 4'b0001;
    bus.ar_ready_i = 1'b1;
    for (int k = 0; k < MAX_OUTST; k++) begin
      #1;
      total++; if (bus.ch_req_ready_o !== 4'b0001) begin bad++; $display("FAIL limit_fill k=%0d got=%b exp=0001", k, bus.ch_req_ready_o); end
      step();
    end
    bus.ch_req_valid_i = 4'b0011;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0010) begin bad++; $display("FAIL limit_block got=%b exp=0010", bus.ch_req_ready_o); end
    step();
    bus.ch_req_valid_i = 4'b0001;
    bus.r_valid_i = 1'b1; bus.r_id_i = '0; bus.r_last_i = 1'b1; bus.ch_resp_ready_i = 4'b0001;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0000) begin bad++; $display("FAIL limit_still_blocked got=%b exp=0000", bus.ch_req_ready_o); end
    step();
    bus.r_valid_i = 1'b0; bus.r_last_i = 1'b0;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0001) begin bad++; $display("FAIL limit_release got=%b exp=0001", bus.ch_req_ready_o); end
    step();
    bus.ch_req_valid_i = '0;
    step();
  endtask

  task automatic test_resp();
    bus.r_valid_i = 1'b1; bus.r_id_i = ID_W'(2); bus.r_last_i = 1'b0;
    bus.ch_resp_ready_i = '0; bus.r_resp_i = 2'b00;
    #1;
    total++; if (bus.r_ready_o !== 1'b0) begin bad++; $display("FAIL resp_bp_ready got=%b exp=0", bus.r_ready_o); end
    total++; if (bus.ch_resp_valid_o !== 4'b0100) begin bad++; $display("FAIL resp_bp_valid got=%b exp=0100", bus.ch_resp_valid_o); end
    total++; if (bus.ch_resp_err_o !== 1'b0) begin bad++; $display("FAIL resp_okay_err got=%b exp=0", bus.ch_resp_err_o); end
    bus.ch_resp_ready_i = 4'b0100; bus.r_resp_i = 2'b10;
    #1;
    total++; if (bus.r_ready_o !== 1'b1) begin bad++; $display("FAIL resp_ready got=%b exp=1", bus.r_ready_o); end
    total++; if (bus.ch_resp_err_o !== 1'b1) begin bad++; $display("FAIL resp_slverr got=%b exp=1", bus.ch_resp_err_o); end
    step();
    bus.r_id_i = ID_W'(7); bus.r_resp_i = 2'b00; bus.ch_resp_ready_i = '0;
    #1;
    total++; if (bus.r_ready_o !== 1'b1) begin bad++; $display("FAIL stray_ready got=%b exp=1", bus.r_ready_o); end
    total++; if (bus.ch_resp_valid_o !== 4'b0000) begin bad++; $display("FAIL stray_valid got=%b exp=0000", bus.ch_resp_valid_o); end
    total++; if (bus.stray_id_o !== 1'b0) begin bad++; $display("FAIL stray_early got=%b exp=0", bus.stray_id_o); end
    step();
    bus.r_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus.stray_id_o !== 1'b1) begin bad++; $display("FAIL stray_sticky k=%0d got=%b exp=1", k, bus.stray_id_o); end
      step();
    end
  endtask

  task automatic test_simul_and_reset();
    do_reset();
    set_req(0, 40'hC000, 8'd0);
    set_req(1, 40'hC100, 8'd2);
    bus.ar_ready_i = 1'b1;
    bus.ch_req_valid_i = 4'b0001;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0001) begin bad++; $display("FAIL simul_first got=%b exp=0001", bus.ch_req_ready_o); end
    step();
    bus.r_valid_i = 1'b1; bus.r_id_i = '0; bus.r_last_i = 1'b1; bus.ch_resp_ready_i = 4'b0001;
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0001) begin bad++; $display("FAIL simul_same_cycle got=%b exp=0001", bus.ch_req_ready_o); end
    step();
    bus.r_valid_i = 1'b0; bus.r_last_i = 1'b0;
    // One burst outstanding: exactly MAX_OUTST-1 more grants fit.
    for (int k = 0; k < MAX_OUTST - 1; k++) begin
      #1;
      total++; if (bus.ch_req_ready_o !== 4'b0001) begin bad++; $display("FAIL simul_fill k=%0d got=%b exp=0001", k, bus.ch_req_ready_o); end
      step();
    end
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0000) begin bad++; $display("FAIL simul_full got=%b exp=0000", bus.ch_req_ready_o); end
    step();
    bus.ar_ready_i = 1'b0;
    bus.ch_req_valid_i = 4'b0010;
    step();
    bus.ch_req_valid_i = '0;
    bus.r_valid_i = 1'b1; bus.r_id_i = '0; bus.r_last_i = 1'b0;
    #1;
    total++; if (bus.ar_valid_o !== 1'b1) begin bad++; $display("FAIL pre_reset_ar_valid got=%b exp=1", bus.ar_valid_o); end
    step();
    #2;
    rstn = 1'b0;
    #1;
    total++; if (bus.ar_valid_o !== 1'b0) begin bad++; $display("FAIL async_reset_ar_valid got=%b exp=0", bus.ar_valid_o); end
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.r_last_i = 1'b1;
    #1;
    total++; if (bus.ch_resp_valid_o !== 4'b0001 || bus.r_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_route valid=%b ready=%b exp 0001/1", bus.ch_resp_valid_o, bus.r_ready_o); end
    step();
    bus.r_valid_i = 1'b0; bus.r_last_i = 1'b0;
    bus.ar_ready_i = 1'b1;
    bus.ch_req_valid_i = 4'b0001;
    for (int k = 0; k < MAX_OUTST; k++) begin
      #1;
      total++; if (bus.ch_req_ready_o !== 4'b0001) begin bad++; $display("FAIL post_reset_fill k=%0d got=%b exp=0001", k, bus.ch_req_ready_o); end
      step();
    end
    #1;
    total++; if (bus.ch_req_ready_o !== 4'b0000) begin bad++; $display("FAIL post_reset_full got=%b exp=0000", bus.ch_req_ready_o); end
    step();
    bus.ch_req_valid_i = '0;
    step();
  endtask

  task automatic test_random();
    logic [63:0]       a;
    logic [DATA_W-1:0] d;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.ch_req_valid_i = NUM_CH'($urandom());
      for (int c = 0; c < NUM_CH; c++) begin
        a = {$urandom(), $urandom()};
        set_req(c, a[ADDR_W-1:0], 8'($urandom_range(0, 255)));
      end
      d = {$urandom(), $urandom()};
      bus.ar_ready_i      = ($urandom_range(0, 3) != 0);
      bus.r_valid_i       = 1'($urandom_range(0, 1));
      bus.r_id_i          = ID_W'($urandom_range(0, 5));
      bus.r_last_i        = 1'($urandom_range(0, 1));
      bus.r_resp_i        = 2'($urandom_range(0, 3));
      bus.r_data_i        = d;
      bus.ch_resp_ready_i = NUM_CH'($urandom());
      #1;
      total++; if (bus.ch_req_ready_o !== exp_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.ch_req_ready_o, exp_ready()); end
      total++; if (bus.ar_valid_o !== m_av) begin bad++; $display("FAIL rnd_ar_valid cyc=%0d got=%b exp=%b", cyc, bus.ar_valid_o, m_av); end
      total++; if (bus.ar_id_o !== ID_W'(m_id) || bus.ar_addr_o !== m_addr || bus.ar_len_o !== m_len) begin
        bad++; $display("FAIL rnd_ar_payload cyc=%0d got=%0d/%h/%0d exp=%0d/%h/%0d", cyc, bus.ar_id_o, bus.ar_addr_o, bus.ar_len_o, m_id, m_addr, m_len);
      end
      total++; if (bus.r_ready_o !== exp_r_ready()) begin bad++; $display("FAIL rnd_r_ready cyc=%0d got=%b exp=%b", cyc, bus.r_ready_o, exp_r_ready()); end
      total++; if (bus.ch_resp_valid_o !== exp_resp_valid()) begin bad++; $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, bus.ch_resp_valid_o, exp_resp_valid()); end
      total++; if (bus.stray_id_o !== m_stray) begin bad++; $display("FAIL rnd_stray cyc=%0d got=%b exp=%b", cyc, bus.stray_id_o, m_stray); end
      total++; if (bus.ch_resp_err_o !== (bus.r_resp_i != 2'b00) || bus.ch_resp_data_o !== d) begin
        bad++; $display("FAIL rnd_err_data cyc=%0d err=%b data=%h exp_data=%h", cyc, bus.ch_resp_err_o, bus.ch_resp_data_o, d);
      end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_ar_backpressure();
    test_outst_limit();
    test_resp();
    test_simul_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter_n.md
Name: axi_read_arbiter_n

Overview:
- Parametrised N-channel read-request arbiter that merges NUM_CH independent read requesters onto one AXI4 AR/R port.
- Requesters include icache refill, dcache miss, uncached read and page-table walker.
- Successor to the fixed icache/dcache read arbitration in the core's AXI wrapper.
- Adds round-robin fairness, per-channel outstanding-transaction limits, ID-based response routing and error flagging.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
ADDR_W, 40, physical address width
DATA_W, 64, AXI data width; ar_size_o = log2(DATA_W/8)
ID_W, 4, AXI ID width; must be >= clog2(NUM_CH)
MAX_OUTST, 4, maximum in-flight bursts per channel (1..15)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
ch_req_valid_i  in  NUM_CH  per-channel request valid
ch_req_ready_o  out  NUM_CH  per-channel request accepted
ch_req_addr_i  in  NUM_CH*ADDR_W  per-channel address; channel i occupies slice [i*ADDR_W +: ADDR_W]
ch_req_len_i  in  NUM_CH*8  per-channel AXI burst length (beats-1)
ch_resp_valid_o  out  NUM_CH  per-channel response beat valid
ch_resp_ready_i  in  NUM_CH  per-channel response ready
ch_resp_data_o  out  DATA_W  shared response data
ch_resp_last_o  out  1  shared last-beat flag
ch_resp_err_o  out  1  shared error flag; r_resp_i != OKAY
stray_id_o  out  1  sticky; R beat with ID >= NUM_CH was seen
ar_valid_o  out  1  AXI AR valid
ar_ready_i  in  1  AXI AR ready
ar_addr_o  out  ADDR_W  AXI AR address
ar_len_o  out  8  AXI AR length
ar_size_o  out  3  AXI AR size; constant
ar_burst_o  out  2  AXI AR burst; constant INCR (2'b01)
ar_id_o  out  ID_W  AXI AR ID
r_valid_i  in  1  AXI R valid
r_ready_o  out  1  AXI R ready
r_data_i  in  DATA_W  AXI R data
r_id_i  in  ID_W  AXI R ID
r_resp_i  in  2  AXI R response
r_last_i  in  1  AXI R last

Behaviour:
- Reset (async, rstn_i low):
  - ar_valid_o=0; stray_id_o=0.
  - All outstanding counters = 0; round-robin pointer = 0.
  - AR register address/len/ID = 0.
  - The remaining outputs follow from the combinational rules below.
- AR stage is a single output register (slot):
  - slot_free = !ar_valid_o | ar_ready_i.
  - Once ar_valid_o=1, ar_addr_o, ar_len_o and ar_id_o stay stable until ar_ready_i=1.
- Eligibility: channel i is eligible when ch_req_valid_i[i]=1 and outst[i] < MAX_OUTST.
- Grant (combinational, only when slot_free):
  - Winner is the first eligible channel scanning from rr_ptr upward, wrapping modulo NUM_CH.
  - ch_req_ready_o[winner]=1, all other ready bits 0. No grant means all ready bits 0.
  - On grant the slot loads on the next edge: addr, len, id = winner zero-extended to ID_W, and ar_valid_o=1.
  - rr_ptr <= (winner+1) mod NUM_CH on grant; unchanged otherwise.
- Slot drain: slot_free with no grant -> ar_valid_o <= 0.
- Latency: request handshake at cycle N gives ar_valid_o at N+1. Back-to-back grants are possible every cycle while ar_ready_i=1.
- Outstanding counter outst[i]:
  - +1 on grant to i.
  - -1 on an R handshake (r_valid_i & r_ready_o) with r_last_i=1 and r_id_i=i.
  - Both in the same cycle -> unchanged.
  - Saturates at 0: a decrement at 0 is ignored (covers stale responses after reset).
- R routing, combinational, zero latency:
  - If r_id_i < NUM_CH: ch_resp_valid_o[r_id_i] = r_valid_i, all other valid bits 0, and r_ready_o = ch_resp_ready_i[r_id_i].
  - ch_resp_data_o = r_data_i and ch_resp_last_o = r_last_i, unconditionally.
  - ch_resp_err_o = (r_resp_i != 2'b00).
- Stray ID (r_id_i >= NUM_CH, or any bit above clog2(NUM_CH) set):
  - r_ready_o=1 and the beat is dropped.
  - No ch_resp_valid_o is asserted.
  - stray_id_o <= 1; it clears only on reset.
- Ordering: no reordering inside the block. Responses for a channel arrive in AXI same-ID order, and responses for different channels may interleave beat-by-beat.
- Reset mid-burst: all state is cleared immediately. Leftover R beats are still routed by ID and counters stay at 0.

Test Plan:
- Single request: ch1 sends addr=0x80001000, len=3 with ar_ready_i=1. Expect a grant the same cycle, then ar_valid_o=1, ar_id_o=1, ar_len_o=3 on the next cycle. Four R beats with ID 1 go to ch_resp_valid_o[1] only, and outst[1] returns to 0 after the last beat.
- Round robin: all 4 channels valid continuously, ar_ready_i=1, len=0. Grant order is 0,1,2,3,0,1, one grant per cycle.
- AR backpressure: ar_ready_i=0 for 5 cycles while ch2 and ch3 are valid. The first granted request is held stable on AR for all 5 cycles. No further ch_req_ready_o is asserted until ar_ready_i=1.
- Outstanding limit: MAX_OUTST=4, ch0 issues 4 requests with no responses. The 5th is blocked (ch_req_ready_o[0]=0) while ch1 is still granted. One R last beat with ID 0 lets ch0 be granted the next cycle.
- Response backpressure and errors:
  - R beat ID 2 with ch_resp_ready_i[2]=0 gives r_ready_o=0.
  - r_resp_i=2'b10 gives ch_resp_err_o=1.
  - r_id_i=7 with NUM_CH=4 gives r_ready_o=1 and stray_id_o=1 from the next cycle onward.
- Simultaneous increment and decrement plus reset: a ch0 grant and a ch0 last-beat in the same cycle leave outst[0] unchanged. Asserting rstn_i=0 mid-burst drops ar_valid_o immediately. A subsequent ID-0 last beat leaves outst[0]=0.
